rgb_pwm_engine: RTL
===================

Name: rgb_pwm_engine

Overview:
Per-channel PWM generator directly downstream of the RGB LED controller's Wishbone register file. It consumes the duty/period/prescale/enable register values and drives the physical RGB LED pins. Shadow registers make updates glitch-free: new values take effect only at a PWM period boundary. One instance serves all LEDs; all channels share one counter.

Parameters:
NUM_LEDS, 2, number of RGB LEDs (3 channels each)
CNT_W, 16, width of period counter and duty values
PRE_W, 8, width of clock prescaler

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous reset, active-low
i_run  in  1  global run; 0 holds the engine idle
i_prescale  in  PRE_W  tick every (i_prescale+1) clocks
i_period  in  CNT_W  counter terminal value; PWM period = (i_period+1) ticks
i_duty  in  NUM_LEDS*3*CNT_W  duty per channel; channel c = led*3+k, slice [c*CNT_W +: CNT_W]
i_led_en  in  NUM_LEDS  per-LED enable
i_load  in  1  one-cycle strobe from the register file on any write to period/duty/enable
o_led  out  NUM_LEDS*3  LED drive; per LED bit 2=R, 1=G, 0=B
o_period_end  out  1  one-cycle pulse on counter wrap
o_pending  out  1  load requested but not yet applied

Behaviour:
- Reset (i_rst=0, async): prescaler, counter, and all shadow registers =0; o_led=0, o_period_end=0, o_pending=0.
- Prescaler: pre_cnt counts 0..i_prescale (compared live); tick asserted in the cycle pre_cnt==i_prescale, then pre_cnt returns to 0. i_prescale=0 -> tick every clock.
- Counter: cnt increments on tick; on a tick with cnt>=per_sh it wraps to 0 (>= covers a shadow period shrinking below cnt). o_period_end=1 in the cycle after the wrap tick, for exactly one clock.
- Shadow load: i_load sets pending. On a wrap tick with (pending | i_load), per_sh/duty_sh/en_sh <= live inputs sampled that cycle, and pending clears. A load coinciding with the wrap is applied in that same wrap; no stale pending remains.
- Output (registered, 1-clock latency from cnt): o_led[c] <= en_sh[led] & (cnt < duty_sh[c]).
  - duty=0: constantly off.
  - duty>per_sh: constantly on.
  - per_sh=0: every tick wraps; channel on iff duty>=1.
- Idle (i_run=0): pre_cnt and cnt are held at 0; o_led=0; o_period_end=0. i_load loads shadows immediately in the next clock, and pending stays 0. On 0->1 of i_run, the first tick occurs after i_prescale+1 clocks, with cnt=0 and outputs evaluated from cycle 1.
- Mid-operation reset: all state clears asynchronously and outputs drop the same instant. The first period after reset release uses zeroed shadows (LEDs off) until a load.
- All comparisons are unsigned CNT_W; no arithmetic overflow is possible because cnt never exceeds max(per_sh, 2^CNT_W-1).

Decomposition:
- Shared package rgb_pkg: channel index constants (CH_B=0, CH_G=1, CH_R=2), CH_PER_LED=3, and default CNT_W/PRE_W. The Wishbone register file uses the same package.
- Sub-module rgb_pwm_cmp: one channel's duty shadow, compare, and output flop. It is instantiated NUM_LEDS*3 times via generate. The prescaler, counter, and load control stay in the top.

Test Plan:
- Reset/idle: hold i_rst=0, then release with i_run=0 -> o_led=0, o_period_end never pulses.
- Basic duty: prescale=0, period=9, LED0 R duty=3, G=0, B=10, en=01, load, run -> R high 3 of every 10 clocks, G never high, B always high, o_period_end every 10 clocks, LED1 stays 0.
- Prescale: prescale=3, period=4, duty=2 -> R high 8 clocks of every 20; period_end spacing 20.
- Glitch-free update: mid-period write duty 3->7 with i_load -> o_pending=1, current period still shows 3-clock high, next period shows 7, pending clears at wrap.
- Simultaneous load and wrap: i_load asserted exactly on the wrap tick with period 9->4 -> new period 5 starts immediately, o_pending never asserts.
- Async reset mid-period: assert i_rst=0 while R high -> o_led drops without a clock edge; after release, outputs stay 0 until a new load.

Source files
------------

// File: rtl/rgb_pkg.sv
// Shared RGB LED controller definitions: channel ordering inside an LED and
// default widths. The Wishbone register file imports the same package.
package rgb_pkg;

    localparam int CH_B       = 0;
    localparam int CH_G       = 1;
    localparam int CH_R       = 2;
    localparam int CH_PER_LED = 3;

    localparam int DEF_CNT_W = 16;
    localparam int DEF_PRE_W = 8;

    // Flat channel index of colour k on LED led.
    function automatic int ch_idx(input int led, input int k);
        return led * CH_PER_LED + k;
    endfunction

endpackage

// File: rtl/rgb_pwm_engine_if.sv
// Register-file to PWM-engine bundle: live configuration in, LED drive and status out.
interface rgb_pwm_engine_if #(
    parameter int NUM_LEDS = 2,
    parameter int CNT_W    = 16,
    parameter int PRE_W    = 8
);

    logic                         i_run;
    logic [PRE_W-1:0]             i_prescale;
    logic [CNT_W-1:0]             i_period;
    logic [NUM_LEDS*3*CNT_W-1:0]  i_duty;
    logic [NUM_LEDS-1:0]          i_led_en;
    logic                         i_load;
    logic [NUM_LEDS*3-1:0]        o_led;
    logic                         o_period_end;
    logic                         o_pending;

    modport master (
        output i_run, i_prescale, i_period, i_duty, i_led_en, i_load,
        input  o_led, o_period_end, o_pending
    );

    modport slave (
        input  i_run, i_prescale, i_period, i_duty, i_led_en, i_load,
        output o_led, o_period_end, o_pending
    );

endinterface

// File: rtl/rgb_pwm_cmp.sv
// One PWM channel: duty shadow register, compare against the shared counter,
// and the registered LED drive.
module rgb_pwm_cmp #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ld,
    input  logic [CNT_W-1:0] i_duty,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic             i_en,
    input  logic             i_run,
    output logic             o_led
);

    logic [CNT_W-1:0] duty_sh_q, duty_sh_d;
    logic             led_q, led_d;

    always_comb begin
        duty_sh_d = i_ld ? i_duty : duty_sh_q;
        // duty above the period keeps the compare true for the whole period
        led_d     = i_run && i_en && (i_cnt < duty_sh_q);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            duty_sh_q <= '0;
            led_q     <= 1'b0;
        end else begin
            duty_sh_q <= duty_sh_d;
            led_q     <= led_d;
        end
    end

    assign o_led = led_q;

endmodule

// File: rtl/rgb_pwm_engine.sv
// Multi-LED PWM engine: shared prescaler and period counter, shadowed
// period/enable, and one compare channel per colour.
module rgb_pwm_engine
    import rgb_pkg::*;
#(
    parameter int NUM_LEDS = 2,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int PRE_W    = DEF_PRE_W
) (
    input  logic           i_clk,
    input  logic           i_rst,
    rgb_pwm_engine_if.slave bus
);

    localparam int NUM_CH = NUM_LEDS * CH_PER_LED;

    logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    per_sh_q, per_sh_d;
    logic [NUM_LEDS-1:0] en_sh_q, en_sh_d;
    logic                pending_q, pending_d;
    logic                period_end_q, period_end_d;
    logic                tick, wrap, sh_ld;
    logic [NUM_CH-1:0]   led;

    always_comb begin
        pre_cnt_d    = '0;
        cnt_d        = '0;
        pending_d    = 1'b0;
        period_end_d = 1'b0;
        sh_ld        = 1'b0;
        tick         = bus.i_run && (pre_cnt_q == bus.i_prescale);
        // >= also catches a shadow period that shrank below the running count
        wrap         = tick && (cnt_q >= per_sh_q);

        if (!bus.i_run) begin
            // idle: counters parked at zero, writes land in the shadows at once
            sh_ld = bus.i_load;
        end else begin
            pre_cnt_d    = tick ? '0 : pre_cnt_q + PRE_W'(1);
            if (wrap)
                cnt_d = '0;
            else if (tick)
                cnt_d = cnt_q + CNT_W'(1);
            else
                cnt_d = cnt_q;
            sh_ld        = wrap && (pending_q || bus.i_load);
            pending_d    = !sh_ld && (pending_q || bus.i_load);
            period_end_d = wrap;
        end

        per_sh_d = sh_ld ? bus.i_period   : per_sh_q;
        en_sh_d  = sh_ld ? bus.i_led_en   : en_sh_q;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            pre_cnt_q    <= '0;
            cnt_q        <= '0;
            per_sh_q     <= '0;
            en_sh_q      <= '0;
            pending_q    <= 1'b0;
            period_end_q <= 1'b0;
        end else begin
            pre_cnt_q    <= pre_cnt_d;
            cnt_q        <= cnt_d;
            per_sh_q     <= per_sh_d;
            en_sh_q      <= en_sh_d;
            pending_q    <= pending_d;
            period_end_q <= period_end_d;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        rgb_pwm_cmp #(
            .CNT_W (CNT_W)
        ) u_cmp (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_ld   (sh_ld),
            .i_duty (bus.i_duty[c*CNT_W +: CNT_W]),
            .i_cnt  (cnt_q),
            .i_en   (en_sh_q[c / CH_PER_LED]),
            .i_run  (bus.i_run),
            .o_led  (led[c])
        );
    end

    assign bus.o_led        = led;
    assign bus.o_period_end = period_end_q;
    assign bus.o_pending    = pending_q;

endmodule
